// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel fractional clock-enable generator.
//
// Sits directly behind the board PLL. The raw lock is filtered until it has
// stayed high for LOCK_FILTER consecutive cycles, then each channel runs a
// phase accumulator whose carry-out is a one-cycle enable pulse. Channel i
// pulses at an average rate of f_clk * inc_i / 2^ACC_W, with no drift.
//
// Ports:
//   clk       PLL output clock, rising edge
//   rst       synchronous active-high reset
//   pll_lock  raw PLL lock (already synchronous to clk)
//   inc_we    increment write strobe
//   inc_sel   channel select for the write (out-of-range selects are ignored)
//   inc_data  new increment value
//   sync      phase-align: clears every accumulator while running
//   ready     high while the generator is in RUN
//   ce        per-channel single-cycle enable pulses

// One enable channel: increment register plus phase accumulator.
//   adv      add this cycle; when low the accumulator is held at phase 0
//   wr_en    load wr_data into the increment register
module clk_enable_lane #(
  parameter int              ACC_W    = 24,
  parameter logic [ACC_W-1:0] INIT_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_data,
  output logic             ce
);
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit so the carry is the pulse and acc wraps mod 2^ACC_W.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      inc <= INIT_INC;
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      // The add below still sees the old increment; a write lands next edge.
      if (wr_en) inc <= wr_data;
      if (adv) begin
        {ce, acc} <= sum;
      end else begin
        acc <= '0;
        ce  <= 1'b0;
      end
    end
  end
endmodule

module clk_enable_gen #(
  parameter int               CHANNELS    = 3,
  parameter int               ACC_W       = 24,
  parameter int               LOCK_FILTER = 1023,
  parameter logic [ACC_W-1:0] INIT_INC    = 24'h1C71C7,
  localparam int              CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_lock,
  input  logic                inc_we,
  input  logic [CH_W-1:0]     inc_sel,
  input  logic [ACC_W-1:0]    inc_data,
  input  logic                sync,
  output logic                ready,
  output logic [CHANNELS-1:0] ce
);
  localparam int CNT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_FILT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             adv;
  logic [CHANNELS-1:0] lane_we;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_WAIT: if (pll_lock) begin
        state_nx = S_FILT;
        cnt_nx   = '0;
      end
      S_FILT: begin
        // Any low cycle throws away all accumulated lock credit.
        if (!pll_lock) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = S_RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_RUN: if (!pll_lock) state_nx = S_WAIT;
      default: begin
        state_nx = S_WAIT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_WAIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // Registered from the next state so ready drops on the lock-loss edge.
      ready <= (state_nx == S_RUN);
    end
  end

  // Lock loss in RUN and sync both clear the phase on the same edge.
  assign adv = (state == S_RUN) && pll_lock && !sync;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_we
    // Only in-range selects can match, so out-of-range writes fall away.
    assign lane_we[i] = inc_we && (inc_sel == CH_W'(i));
  end

  clk_enable_lane #(
    .ACC_W    (ACC_W),
    .INIT_INC (INIT_INC)
  ) u_lane [CHANNELS-1:0] (
    .clk     (clk),
    .rst     (rst),
    .adv     (adv),
    .wr_en   (lane_we),
    .wr_data (inc_data),
    .ce      (ce)
  );
endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;
  localparam int LF = 4;

  logic        clk;
  logic        a_rst, a_lock, a_we, a_sync, a_ready;
  logic [1:0]  a_sel;
  logic [23:0] a_data;
  logic [2:0]  a_ce;
  logic        b_rst, b_lock, b_we, b_sync, b_ready;
  logic [0:0]  b_sel;
  logic [7:0]  b_data;
  logic [0:0]  b_ce;

  clk_enable_gen #(.CHANNELS(3), .ACC_W(24), .LOCK_FILTER(LF), .INIT_INC(24'h1C71C7)) u_a (
    .clk(clk), .rst(a_rst), .pll_lock(a_lock), .inc_we(a_we), .inc_sel(a_sel),
    .inc_data(a_data), .sync(a_sync), .ready(a_ready), .ce(a_ce));

  clk_enable_gen #(.CHANNELS(1), .ACC_W(8), .LOCK_FILTER(LF), .INIT_INC(8'd1)) u_b (
    .clk(clk), .rst(b_rst), .pll_lock(b_lock), .inc_we(b_we), .inc_sel(b_sel),
    .inc_data(b_data), .sync(b_sync), .ready(b_ready), .ce(b_ce));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit rdy; bit [2:0] ce; } exp_t;
  exp_t qa[$], qb[$];

  int n_chk = 0, n_pass = 0;
  int wdt[2]     = '{24, 8};
  int chn[2]     = '{3, 1};
  longint init_m[2] = '{longint'(24'h1C71C7), 1};

  // Reference state: each channel's pulses are the floor-difference of
  // (base + n*inc) / 2^W, where base is the phase at the start of the
  // current segment and n counts adds since then.
  longint inc_m[2][3], base_m[2][3], n_m[2][3];
  int     streak[2];
  bit     rdy_m[2];

  bit cnt_a, cnt_b;
  int pa[3];
  int b_pulses, b_lows;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model(input int d, input bit rst, input bit lock, input bit we,
                       input int sel, input longint data, input bit sync, output exp_t e);
    longint m = longint'(1) << wdt[d];
    e.rdy = 1'b0;
    e.ce  = '0;
    if (rst) begin
      streak[d] = 0;
      rdy_m[d]  = 1'b0;
      for (int c = 0; c < 3; c++) begin
        inc_m[d][c] = init_m[d]; base_m[d][c] = 0; n_m[d][c] = 0;
      end
      return;
    end
    for (int c = 0; c < chn[d]; c++) begin
      if (rdy_m[d] && lock && !sync) begin
        n_m[d][c]++;
        e.ce[c] = ((base_m[d][c] + n_m[d][c] * inc_m[d][c]) / m -
                   (base_m[d][c] + (n_m[d][c] - 1) * inc_m[d][c]) / m) != 0;
      end else begin
        base_m[d][c] = 0; n_m[d][c] = 0;
      end
    end
    if (we && sel < chn[d]) begin
      base_m[d][sel] = (base_m[d][sel] + n_m[d][sel] * inc_m[d][sel]) % m;
      n_m[d][sel]    = 0;
      inc_m[d][sel]  = data;
    end
    streak[d] = lock ? streak[d] + 1 : 0;
    rdy_m[d]  = streak[d] > LF;
    e.rdy     = rdy_m[d];
  endtask

  // Predict both DUTs for the coming edge, then advance one cycle.
  task automatic tick();
    exp_t ea, eb;
    model(0, a_rst, a_lock, a_we, int'(a_sel), longint'(a_data), a_sync, ea);
    model(1, b_rst, b_lock, b_we, int'(b_sel), longint'(b_data), b_sync, eb);
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
    @(negedge clk);
    a_we = 0; a_sync = 0; a_rst = 0;
    b_we = 0; b_sync = 0;
  endtask

  always @(posedge clk) begin
    exp_t ea, eb;
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_ready", 32'(a_ready), 32'(ea.rdy));
      chk("a_ce", 32'(a_ce), 32'(ea.ce));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_ready", 32'(b_ready), 32'(eb.rdy));
      chk("b_ce", 32'(b_ce), 32'(eb.ce[0]));
    end
    if (cnt_a) for (int c = 0; c < 3; c++) pa[c] += int'(a_ce[c]);
    if (cnt_b) begin
      b_pulses += int'(b_ce[0]);
      b_lows   += int'(!b_ce[0]);
    end
  end

  initial begin
    a_rst = 1; a_lock = 0; a_we = 0; a_sel = 0; a_data = 0; a_sync = 0;
    b_rst = 1; b_lock = 0; b_we = 0; b_sel = 0; b_data = 0; b_sync = 0;
    cnt_a = 0; cnt_b = 0; b_pulses = 0; b_lows = 0;
    for (int c = 0; c < 3; c++) pa[c] = 0;
    @(negedge clk);
    a_rst = 1; tick();
    a_rst = 1; tick();
    b_rst = 0;

    // ch0 = 1/4 rate written before lock, then filter and run
    a_we = 1; a_sel = 0; a_data = 24'h400000; tick();
    a_lock = 1;
    repeat (4) tick();
    repeat (40) tick();

    // phase-align, then a 9000-cycle rate window
    a_sync = 1; tick();
    cnt_a = 1;
    repeat (9000) tick();
    cnt_a = 0;
    chk("a_cnt_ch0", 32'(pa[0]), 32'd2250);
    chk("a_cnt_ch1", 32'(pa[1]), 32'd999);
    chk("a_cnt_ch2", 32'(pa[2]), 32'd999);

    // lock glitch in RUN, then a glitch during re-filter
    a_lock = 0; tick();
    a_lock = 1; repeat (2) tick();
    a_lock = 0; tick();
    a_lock = 1; repeat (12) tick();

    // sync together with a write to ch1, then an out-of-range write
    a_sync = 1; a_we = 1; a_sel = 1; a_data = 24'h800000; tick();
    repeat (20) tick();
    a_we = 1; a_sel = 3; a_data = 24'h123456; tick();
    repeat (20) tick();

    // randomized traffic, including occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      a_lock = ($urandom_range(199) != 0);
      a_sync = ($urandom_range(49) == 0);
      a_rst  = ($urandom_range(999) == 0);
      if ($urandom_range(15) == 0) begin
        a_we  = 1;
        a_sel = 2'($urandom_range(3));
        case ($urandom_range(3))
          0: a_data = 24'($urandom);
          1: a_data = 24'h0;
          2: a_data = 24'hFFFFFF;
          default: a_data = 24'h400000;
        endcase
      end
      tick();
    end

    // 8-bit instance: inc=255 gives one low cycle per 256
    b_lock = 1; b_we = 1; b_sel = 0; b_data = 8'd255; tick();
    repeat (10) tick();
    b_we = 1; b_sel = 1; b_data = 8'd7; tick();
    b_sync = 1; tick();
    cnt_b = 1;
    repeat (512) tick();
    cnt_b = 0;
    chk("b_lows_512", 32'(b_lows), 32'd2);
    b_pulses = 0;
    b_we = 1; b_sel = 0; b_data = 8'd0; b_sync = 1; tick();
    cnt_b = 1;
    repeat (1000) tick();
    cnt_b = 0;
    chk("b_zero_inc", 32'(b_pulses), 32'd0);

    @(posedge clk); @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
Parametrised multi-channel fractional clock-enable generator driven from the PLL output clock.
- Qualifies the PLL lock signal through a stability filter.
- Generates CHANNELS independent single-cycle clock-enable pulses. Each channel's average rate is f_clk*inc/2^ACC_W, produced by a phase accumulator.
- Sits directly behind the board PLL and supplies CPU/PPU/APU-style enables to the core. Replaces fixed integer dividers with runtime-programmable fractional ratios.

Parameters:
CHANNELS, 3, number of enable channels (>=1)
ACC_W, 24, phase accumulator and increment width in bits (>=4)
LOCK_FILTER, 1023, consecutive lock-high cycles required before enables run (>=1)
INIT_INC, 24'h1C71C7, increment loaded into every channel at reset (~1/9 of 2^24)

Ports:
clk  input  1  PLL output clock; all logic on rising edge
rst  input  1  synchronous active-high reset
pll_lock  input  1  raw PLL lock, treated as already synchronous to clk
inc_we  input  1  increment write strobe
inc_sel  input  CH_W  channel select for write; CH_W = max(1, clog2(CHANNELS))
inc_data  input  ACC_W  new increment value
sync  input  1  phase-align: clear all accumulators
ready  output  1  high while in RUN state
ce  output  CHANNELS  per-channel one-cycle enable pulses

Behaviour:
- Reset (rst=1 at an edge):
  - state=WAIT_LOCK, lock counter=0, all accumulators=0.
  - All increments=INIT_INC.
  - ready=0, ce=0.
  - Reset has priority over everything and may occur mid-operation with the same result.
- FSM states: WAIT_LOCK, FILTER, RUN.
  - WAIT_LOCK: pll_lock=1 -> FILTER with cnt=0; else stay.
  - FILTER:
    - pll_lock=0 -> WAIT_LOCK, cnt=0.
    - Else if cnt==LOCK_FILTER-1 -> RUN.
    - Else cnt++.
  - RUN: pll_lock=0 -> WAIT_LOCK on that edge. Accumulators cleared, ce forced 0, ready 0 on the same edge.
- ready is registered (ready = state==RUN). With pll_lock held high from edge 0, ready is first high after edge LOCK_FILTER.
- Any lock-low cycle during FILTER restarts filtering from zero. No partial credit.
- Accumulator, per channel i, each edge while in RUN and sync=0:
  - {carry, acc_i} <= acc_i + inc_i, computed ACC_W+1 bits wide, so acc wraps mod 2^ACC_W.
  - ce[i] <= carry.
  - ce is registered: a pulse is high for exactly the cycle following the overflowing add.
- Rate and jitter:
  - Pulses over any N-cycle window equal floor((acc0 + N*inc)/2^ACC_W); no drift.
  - inc=0 -> ce[i] never asserts.
  - inc=2^ACC_W-1 -> ce[i] low exactly once per 2^ACC_W cycles.
- sync=1 in RUN clears all accumulators to 0 and drives ce=0 on that edge. It has priority over accumulation.
- sync outside RUN has no effect (accumulators are already 0).
- Increment write:
  - inc_we=1 with inc_sel<CHANNELS loads inc_data into that channel on the edge.
  - The new value is used by the add on the following edge.
  - inc_sel>=CHANNELS is ignored.
  - Writes are accepted in every state. Increments survive lock loss; only rst restores INIT_INC.
  - A write coinciding with sync: both take effect. The accumulator clears and the new increment applies from the next edge.
- Outside RUN: ce=0 and accumulators hold 0. The first add after entering RUN starts from phase 0.

Test Plan:
- LOCK_FILTER=4, rst for 2 cycles, then pll_lock=1 from edge 0 -> ready=0 through edge 3, ready=1 after edge 4; ce=0 throughout filtering.
- ACC_W=24, write ch0 inc=24'h400000 before lock -> in RUN, ch0 pulses every 4 cycles, first pulse 4 cycles after ready rises.
- Default INIT_INC on all channels, 9000 cycles in RUN -> exactly 999 pulses per channel, spacing 9 or 10 cycles, all channels identical.
- In RUN, drop pll_lock for 1 cycle -> ready=0 and ce=0 on the next edge, re-filter takes full LOCK_FILTER. A glitch during FILTER restarts the count. Increments are unchanged.
- In RUN, assert sync together with a write of ch1 inc=24'h800000 -> all acc=0, ce=0 that cycle; ch1 then pulses every 2 cycles phase-aligned to the other channels. A write with inc_sel=3 (CHANNELS=3) leaves all increments unchanged.
- ACC_W=8, inc=255 -> ce[0] low exactly 1 cycle in each 256. inc=0 -> no pulses over 1000 cycles.
